// File: rtl/noc_out_port.sv
// Router output port: registers the granted flit onto the link,
// tracks downstream credits, and owns the round-robin turn vector.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   port_enable          grant from routing logic this cycle
//   port_select          source input 0=N 1=S 2=E 3=W 4=L
//   N/S/E/W/L_data_i     head flit of each input FIFO
//   credit_return_i      downstream freed one buffer slot
//   data_o, valid_o      registered link flit, one-cycle valid pulse
//   port_full            no credits left (from credit register only)
//   turn                 one-hot round-robin owner {N,S,E,W,L}
//   err_o                sticky protocol-violation flag
module noc_out_port #(
  parameter int DATA_W = 8,
  parameter int CREDITS = 4,
  parameter int CRED_W = 3,
  parameter logic [4:0] IN_MASK = 5'b11111,
  parameter logic [4:0] INIT_TURN = 5'b10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_enable,
  input  logic [2:0]        port_select,
  input  logic [DATA_W-1:0] N_data_i,
  input  logic [DATA_W-1:0] S_data_i,
  input  logic [DATA_W-1:0] E_data_i,
  input  logic [DATA_W-1:0] W_data_i,
  input  logic [DATA_W-1:0] L_data_i,
  input  logic              credit_return_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              port_full,
  output logic [4:0]        turn,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] L_CMAX =
    CRED_W'(CREDITS);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CRED_W-1:0] r_cred;
  logic [4:0]        r_turn;
  logic              r_err;

  logic [4:0]        w_sel_oh;
  logic [DATA_W-1:0] w_mux;
  logic              w_accept;
  logic              w_reject;
  logic              w_ovf;
  logic [9:0]        w_dbl;
  logic [4:0]        w_cand;
  logic [4:0]        w_turn_nxt;
  logic              w_found;

  always_comb begin
    w_sel_oh = 5'b00000;
    w_mux = '0;
    case (port_select)
      3'd0: begin
        w_sel_oh = 5'b10000;
        w_mux = N_data_i;
      end
      3'd1: begin
        w_sel_oh = 5'b01000;
        w_mux = S_data_i;
      end
      3'd2: begin
        w_sel_oh = 5'b00100;
        w_mux = E_data_i;
      end
      3'd3: begin
        w_sel_oh = 5'b00010;
        w_mux = W_data_i;
      end
      3'd4: begin
        w_sel_oh = 5'b00001;
        w_mux = L_data_i;
      end
      default: begin
        w_sel_oh = 5'b00000;
        w_mux = '0;
      end
    endcase
  end

  assign port_full = (r_cred == '0);

  // Out-of-range selects decode to zero, which never matches
  // a one-hot turn, so they are rejected here too.
  assign w_accept = port_enable & ~port_full
                  & (w_sel_oh == r_turn)
                  & (|(w_sel_oh & IN_MASK));
  assign w_reject = port_enable & ~w_accept;
  assign w_ovf = credit_return_i & ~w_accept
               & (r_cred == L_CMAX);

  // Rotating right by i moves ownership i steps along
  // N->S->E->W->L; take the first step landing in IN_MASK.
  assign w_dbl = {r_turn, r_turn};

  always_comb begin
    w_turn_nxt = r_turn;
    w_found = 1'b0;
    w_cand = r_turn;
    for (int i = 1; i <= 5; i++) begin
      w_cand = w_dbl[i +: 5];
      if (!w_found && (|(w_cand & IN_MASK))) begin
        w_turn_nxt = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_valid <= 1'b0;
      r_cred <= L_CMAX;
      r_turn <= INIT_TURN;
      r_err <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data <= w_mux;
      end
      if (w_reject | w_ovf) begin
        r_err <= 1'b1;
      end
      case ({w_accept, credit_return_i})
        2'b10: r_cred <= r_cred - 1'b1;
        2'b01: begin
          if (r_cred != L_CMAX) begin
            r_cred <= r_cred + 1'b1;
          end
        end
        default: r_cred <= r_cred;
      endcase
      // Freeze while starved so the current owner goes first
      // once credits come back.
      if (!port_full) begin
        r_turn <= w_turn_nxt;
      end
    end
  end

  assign data_o = r_data;
  assign valid_o = r_valid;
  assign turn = r_turn;
  assign err_o = r_err;

endmodule

// File: tb/tb_noc_out_port.sv
// Randomized scoreboard bench for noc_out_port: a full-mask port
// and an S/W/L-only port share stimulus and are checked each cycle.
module tb_noc_out_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       port_enable = 1'b0;
  logic [2:0] port_select = 3'd0;
  logic [7:0] n_d = 8'd0, s_d = 8'd0, e_d = 8'd0;
  logic [7:0] w_d = 8'd0, l_d = 8'd0;
  logic       cret = 1'b0;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_full, b_full;
  logic       a_err, b_err;
  logic [4:0] a_turn, b_turn;

  always #5 clk = ~clk;

  noc_out_port dut_a (
    .clk(clk), .rst(rst),
    .port_enable(port_enable), .port_select(port_select),
    .N_data_i(n_d), .S_data_i(s_d), .E_data_i(e_d),
    .W_data_i(w_d), .L_data_i(l_d),
    .credit_return_i(cret),
    .data_o(a_data), .valid_o(a_valid), .port_full(a_full),
    .turn(a_turn), .err_o(a_err)
  );

  noc_out_port #(
    .IN_MASK(5'b01011), .INIT_TURN(5'b01000)
  ) dut_b (
    .clk(clk), .rst(rst),
    .port_enable(port_enable), .port_select(port_select),
    .N_data_i(n_d), .S_data_i(s_d), .E_data_i(e_d),
    .W_data_i(w_d), .L_data_i(l_d),
    .credit_return_i(cret),
    .data_o(b_data), .valid_o(b_valid), .port_full(b_full),
    .turn(b_turn), .err_o(b_err)
  );

  typedef struct {
    int   cred;
    int   tidx;
    bit   err;
    logic [7:0] data;
    bit   valid;
  } mst_t;

  typedef struct {
    mst_t a;
    mst_t b;
  } exp_t;

  exp_t exp_q[$];
  mst_t ma, mb;
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural port model; tidx 0..4 means owner N..L.
  function automatic mst_t step(mst_t s, logic [4:0] mask,
      int init_t, bit r, bit en, int sel, bit ret,
      logic [39:0] din);
    mst_t o;
    bit ok;
    int t;
    o = s;
    if (r) begin
      o.cred = 4;
      o.tidx = init_t;
      o.err = 0;
      o.data = 8'd0;
      o.valid = 0;
      return o;
    end
    ok = en && (s.cred != 0) && (sel <= 4)
       && (sel == s.tidx) && mask[4-sel];
    o.valid = ok;
    if (ok) o.data = din[(4-sel)*8 +: 8];
    if (en && !ok) o.err = 1;
    o.cred = s.cred - (ok ? 1 : 0) + (ret ? 1 : 0);
    if (o.cred > 4) begin
      o.cred = 4;
      o.err = 1;
    end
    if (s.cred != 0) begin
      t = s.tidx;
      for (int k = 0; k < 5; k++) begin
        t = (t + 1) % 5;
        if (mask[4-t]) break;
      end
      o.tidx = t;
    end
    return o;
  endfunction

  task automatic drive(bit r, bit en, int sel, bit ret,
      bit force_l);
    logic [39:0] din;
    exp_t e;
    @(negedge clk);
    din = {$urandom, $urandom_range(255, 0)};
    if (force_l) din[7:0] = 8'h23;
    rst = r;
    port_enable = en;
    port_select = 3'(sel);
    cret = ret;
    {n_d, s_d, e_d, w_d, l_d} = din;
    ma = step(ma, 5'b11111, 0, r, en, sel, ret, din);
    mb = step(mb, 5'b01011, 1, r, en, sel, ret, din);
    e.a = ma;
    e.b = mb;
    exp_q.push_back(e);
  endtask

  task automatic check(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
        nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a.valid", int'(a_valid), int'(e.a.valid));
        check("a.data", int'(a_data), int'(e.a.data));
        check("a.full", int'(a_full), int'(e.a.cred == 0));
        check("a.turn", int'(a_turn),
          int'(5'b10000 >> e.a.tidx));
        check("a.err", int'(a_err), int'(e.a.err));
        check("b.valid", int'(b_valid), int'(e.b.valid));
        check("b.data", int'(b_data), int'(e.b.data));
        check("b.full", int'(b_full), int'(e.b.cred == 0));
        check("b.turn", int'(b_turn),
          int'(5'b10000 >> e.b.tidx));
        check("b.err", int'(b_err), int'(e.b.err));
      end
    end
  end

  initial begin : stim
    int sel;
    int p;
    ma = '{4, 0, 0, 8'd0, 0};
    mb = '{4, 1, 0, 8'd0, 0};
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && ma.tidx != 4; i++)
      drive(0, 0, 0, 0, 0);
    drive(0, 1, 4, 0, 1);
    for (int i = 0; i < 10 && ma.cred > 0; i++)
      drive(0, 1, ma.tidx, 0, 0);
    drive(0, 1, ma.tidx, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 2, 0, 0);
    drive(0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, ma.tidx, 0, 0);
    drive(0, 1, ma.tidx, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(99, 0);
      if (p < 50) sel = ma.tidx;
      else if (p < 80) sel = mb.tidx;
      else sel = $urandom_range(7, 0);
      drive($urandom_range(99, 0) < 2,
            $urandom_range(99, 0) < 60, sel,
            $urandom_range(99, 0) < 30, 0);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
      n_cmp, n_bad);
    $finish;
  end

endmodule
